// File: rtl/tile_match_responder.sv
// Responder end of the game-control compare protocol: builds an LFSR tile track, then scores key compares.
// Optional feature: define MISS_PENALTY_EN to step the player back one tile on a miss.
module tile_match_responder #(
    parameter int unsigned TRACK_LEN = 16,
    parameter int unsigned TILE_W    = 3,
    parameter logic [15:0] SEED_DEF  = 16'hACE1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic              A,
    input  logic [TILE_W-1:0] key_code,
    output logic              c,
    output logic              go,
    output logic              win,
    output logic              rsp_valid,
    output logic [5:0]        pos,
    output logic [TILE_W-1:0] tile_cur
);

    localparam int unsigned ADDR_W = (TRACK_LEN > 1) ? $clog2(TRACK_LEN) : 1;
    localparam int unsigned IDX_W  = $clog2(TRACK_LEN + 1);
    localparam logic [5:0]       LAST_POS = 6'(TRACK_LEN);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(TRACK_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2,
        WON   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [5:0]         pos_q, pos_d;
    logic               c_q, c_d;
    logic               go_q, go_d;
    logic               win_q, win_d;
    logic               rsp_q, rsp_d;
    logic [TILE_W-1:0]  tiles_q [TRACK_LEN];

    logic [15:0]        lfsr_step;
    logic               tile_we;
    logic [TILE_W-1:0]  tile_cur_c;

    assign lfsr_step  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign tile_cur_c = (pos_q == LAST_POS) ? '0 : tiles_q[pos_q[ADDR_W-1:0]];

    // State and control registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_DEF;
            idx_q   <= '0;
            pos_q   <= '0;
            c_q     <= 1'b0;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            c_q     <= c_d;
            go_q    <= go_d;
            win_q   <= win_d;
            rsp_q   <= rsp_d;
        end
    end

    // Track storage; written one tile per GEN cycle from the advanced LFSR value
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < TRACK_LEN; i++) begin
                tiles_q[i] <= '0;
            end
        end else if (tile_we) begin
            tiles_q[idx_q[ADDR_W-1:0]] <= lfsr_step[TILE_W-1:0];
        end
    end

    // Next-state logic; start overrides everything, including a coincident A
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        c_d     = c_q;
        go_d    = go_q;
        win_d   = win_q;
        rsp_d   = 1'b0;
        tile_we = 1'b0;

        if (start) begin
            lfsr_d  = (seed == 16'd0) ? SEED_DEF : seed;
            c_d     = 1'b0;
            go_d    = 1'b0;
            win_d   = 1'b0;
            pos_d   = '0;
            idx_d   = '0;
            state_d = GEN;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                GEN: begin
                    // One extra cycle after the last write raises c
                    if (idx_q == IDX_END) begin
                        c_d     = 1'b1;
                        state_d = READY;
                    end else begin
                        lfsr_d  = lfsr_step;
                        tile_we = 1'b1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                READY: begin
                    if (A) begin
                        rsp_d = 1'b1;
                        if (key_code == tile_cur_c) begin
                            go_d  = 1'b1;
                            pos_d = pos_q + 6'd1;
                            if (pos_q + 6'd1 == LAST_POS) begin
                                win_d   = 1'b1;
                                state_d = WON;
                            end
                        end else begin
                            go_d = 1'b0;
`ifdef MISS_PENALTY_EN
                            if (pos_q != 6'd0) begin
                                pos_d = pos_q - 6'd1;
                            end
`endif
                        end
                    end
                end
                WON: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign c         = c_q;
    assign go        = go_q;
    assign win       = win_q;
    assign rsp_valid = rsp_q;
    assign pos       = pos_q;
    assign tile_cur  = tile_cur_c;

endmodule

// File: tb/tb_tile_match_responder.sv
// Directed, table-driven bench for tile_match_responder (TRACK_LEN=16, TILE_W=3).
module tb_tile_match_responder;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        start;
    logic [15:0] seed;
    logic        A;
    logic [2:0]  key_code;
    logic        c, go, win, rsp_valid;
    logic [5:0]  pos;
    logic [2:0]  tile_cur;

    int tests = 0;
    int fails = 0;

    logic [2:0] mt [16];
    int         mpos;
    int         rsp_cnt;

    tile_match_responder #(.TRACK_LEN(16), .TILE_W(3), .SEED_DEF(16'hACE1)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .seed(seed), .A(A), .key_code(key_code),
        .c(c), .go(go), .win(win), .rsp_valid(rsp_valid), .pos(pos), .tile_cur(tile_cur)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic match;
        logic exp_go;
        int   exp_pos;
        int   exp_pos_pen;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic build_model(input logic [15:0] sd);
        logic [15:0] s;
        s = (sd == 16'd0) ? 16'hACE1 : sd;
        for (int i = 0; i < 16; i++) begin
            s = lfsr_next(s);
            mt[i] = s[2:0];
        end
    endtask

    // Drive a start pulse (optionally with A on the same edge); returns at the negedge after it
    task automatic do_start(input logic [15:0] sd, input logic with_a);
        start = 1'b1; seed = sd; A = with_a; key_code = 3'd0;
        @(negedge CLK);
        start = 1'b0; A = 1'b0;
    endtask

    task automatic wait_c(output int edges);
        edges = 0;
        while (!c && edges < 40) begin
            @(negedge CLK);
            edges++;
        end
    endtask

    task automatic send_a(input logic [2:0] key);
        A = 1'b1; key_code = key;
        @(negedge CLK);
        A = 1'b0;
    endtask

    task automatic play_to_win();
        int guard;
        guard = 0;
        while (mpos < 16 && guard < 20) begin
            send_a(mt[mpos]);
            mpos++;
            guard++;
            if (rsp_valid) rsp_cnt++;
            chk("play_rsp", 32'(rsp_valid), 32'd1);
            chk("play_go", 32'(go), 32'd1);
            chk("play_pos", 32'(pos), 32'(mpos));
            chk("play_win", 32'(win), (mpos == 16) ? 32'd1 : 32'd0);
            chk("play_tile", 32'(tile_cur), (mpos < 16) ? 32'(mt[mpos]) : 32'd0);
            @(negedge CLK);
            chk("play_rsp_drop", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int edges;
        int seen;
        logic [2:0] k;

        vecs[0] = '{1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 1, 1};
        vecs[2] = '{1'b1, 1'b1, 2, 2};
        vecs[3] = '{1'b1, 1'b1, 3, 3};
        vecs[4] = '{1'b1, 1'b1, 4, 4};
        vecs[5] = '{1'b1, 1'b1, 5, 5};
        vecs[6] = '{1'b0, 1'b0, 5, 4};
        vecs[7] = '{1'b0, 1'b0, 5, 3};

        RSTn = 1'b0; start = 1'b0; seed = 16'd0; A = 1'b0; key_code = 3'd0;
        @(negedge CLK); @(negedge CLK);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_tile", 32'(tile_cur), 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Generation with seed 1 while A is held high the whole time
        build_model(16'h0001);
        do_start(16'h0001, 1'b0);
        edges = 0; seen = 0; A = 1'b1; key_code = 3'd0;
        while (!c && edges < 40) begin
            @(negedge CLK);
            edges++;
            if (rsp_valid) seen = 1;
        end
        A = 1'b0;
        chk("gen_latency", 32'(edges), 32'd17);
        chk("gen_a_ignored", 32'(seen), 32'd0);
        chk("gen_pos0", 32'(pos), 32'd0);
        chk("gen_tile0", 32'(tile_cur), 32'(mt[0]));

        // Table of hits and misses from position 0
        mpos = 0;
        for (int i = 0; i < 8; i++) begin
            k = vecs[i].match ? mt[mpos] : (mt[mpos] ^ 3'd1);
            send_a(k);
`ifdef MISS_PENALTY_EN
            mpos = vecs[i].exp_pos_pen;
`else
            mpos = vecs[i].exp_pos;
`endif
            chk($sformatf("vec%0d_rsp", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_go", i), 32'(go), 32'(vecs[i].exp_go));
            chk($sformatf("vec%0d_pos", i), 32'(pos), 32'(mpos));
            chk($sformatf("vec%0d_tile", i), 32'(tile_cur), 32'(mt[mpos]));
            chk($sformatf("vec%0d_win", i), 32'(win), 32'd0);
            @(negedge CLK);
            chk($sformatf("vec%0d_rsp_drop", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("vec%0d_go_hold", i), 32'(go), 32'(vecs[i].exp_go));
        end

        rsp_cnt = 0;
        play_to_win();
        chk("won_c", 32'(c), 32'd1);

        // A after win is ignored
        send_a(3'd0);
        chk("won_a_rsp", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        chk("won_a_rsp2", 32'(rsp_valid), 32'd0);
        chk("won_pos", 32'(pos), 32'd16);
        chk("won_hold", 32'({c, go, win}), 32'd7);

        // Restart from WON with seed 0 (uses SEED_DEF)
        build_model(16'h0000);
        do_start(16'h0000, 1'b0);
        chk("restart_win", 32'(win), 32'd0);
        chk("restart_go", 32'(go), 32'd0);
        chk("restart_c", 32'(c), 32'd0);
        chk("restart_pos", 32'(pos), 32'd0);
        wait_c(edges);
        chk("restart_latency", 32'(edges), 32'd17);
        chk("seed0_tile0", 32'(tile_cur), 32'(mt[0]));

        // A few hits, then start and A together
        for (int i = 0; i < 3; i++) begin
            send_a(mt[i]);
            chk("pre_start_pos", 32'(pos), 32'(i + 1));
        end
        build_model(16'h0001);
        do_start(16'h0001, 1'b1);
        chk("startA_rsp", 32'(rsp_valid), 32'd0);
        chk("startA_pos", 32'(pos), 32'd0);
        chk("startA_c", 32'(c), 32'd0);
        wait_c(edges);
        chk("regen_latency", 32'(edges), 32'd17);

        // Clean full game: 16 hits
        mpos = 0; rsp_cnt = 0;
        play_to_win();
        chk("full_rsp_count", 32'(rsp_cnt), 32'd16);
        chk("full_win", 32'(win), 32'd1);

        // Reset while in WON
        RSTn = 1'b0;
        #2;
        chk("rst_won", 32'({c, go, win, rsp_valid}), 32'd0);
        chk("rst_won_pos", 32'(pos), 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        // Reset mid-generation discards the partial track
        do_start(16'h0001, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge CLK);
        RSTn = 1'b0;
        #2;
        chk("rst_gen_c", 32'(c), 32'd0);
        chk("rst_gen_tile", 32'(tile_cur), 32'd0);
        chk("rst_gen_pos", 32'(pos), 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge CLK);
        chk("idle_after_rst_c", 32'(c), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

endmodule
